// File: rtl/wait_fare_counter.sv
// wait_fare_counter: waiting-time fare divider for the taxi meter.
// Counts minute strobes while the cab waits with a passenger. The first
// FREE_MIN minutes are free. After that it emits one wait_fare_pulse per
// billed unit, using separate day and night unit lengths.
// Ports:
//   sys_clk, rst_n   clock; synchronous active-low reset
//   min_pulse        one-cycle strobe per elapsed minute
//   waiting          qualifies min_pulse (cab stopped with passenger)
//   night_mode       selects NIGHT_WAIT_COUNT instead of WAIT_COUNT
//   clear            trip end / new trip, restarts from IDLE
//   wait_fare_pulse  one-cycle pulse per billed unit
//   wait_min         counted minutes this trip (saturating)
//   wait_units       billed units this trip (saturating)
//   free_done        high while billing is active (state BILL)
module wait_fare_counter #(
  parameter int unsigned CNT_W            = 8,
  parameter int unsigned FREE_MIN         = 2,
  parameter int unsigned WAIT_COUNT       = 5,
  parameter int unsigned NIGHT_WAIT_COUNT = 3
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             min_pulse,
  input  logic             waiting,
  input  logic             night_mode,
  input  logic             clear,
  output logic             wait_fare_pulse,
  output logic [CNT_W-1:0] wait_min,
  output logic [CNT_W-1:0] wait_units,
  output logic             free_done
);

  localparam int unsigned     DIV_W     = 8;
  localparam logic [DIV_W:0]  DAY_P     = (DIV_W+1)'(WAIT_COUNT);
  localparam logic [DIV_W:0]  NIGHT_P   = (DIV_W+1)'(NIGHT_WAIT_COUNT);
  localparam logic [DIV_W-1:0] FREE_LIM = DIV_W'(FREE_MIN);
  localparam bit              FREE_NONE = (FREE_MIN == 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FREE = 2'd1,
    BILL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] free_cnt_q, free_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] wait_min_d, wait_units_d;
  logic             pulse_d;
  logic             free_done_d;
  logic             counted;
  logic             bill_minute;
  logic [DIV_W:0]   period;
  logic [DIV_W-1:0] free_next;

  assign counted   = min_pulse & waiting;
  assign period    = night_mode ? NIGHT_P : DAY_P;
  assign free_next = free_cnt_q + DIV_W'(1);

  // State register and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      free_cnt_q      <= '0;
      div_cnt_q       <= '0;
      wait_min        <= '0;
      wait_units      <= '0;
      wait_fare_pulse <= 1'b0;
      free_done       <= 1'b0;
    end else begin
      state_q         <= state_d;
      free_cnt_q      <= free_cnt_d;
      div_cnt_q       <= div_cnt_d;
      wait_min        <= wait_min_d;
      wait_units      <= wait_units_d;
      wait_fare_pulse <= pulse_d;
      free_done       <= free_done_d;
    end
  end

  // Next-state and next-output logic: clear beats a counted minute.
  always_comb begin
    state_d      = state_q;
    free_cnt_d   = free_cnt_q;
    div_cnt_d    = div_cnt_q;
    wait_min_d   = wait_min;
    wait_units_d = wait_units;
    pulse_d      = 1'b0;
    bill_minute  = 1'b0;

    if (clear) begin
      state_d      = IDLE;
      free_cnt_d   = '0;
      div_cnt_d    = '0;
      wait_min_d   = '0;
      wait_units_d = '0;
    end else if (counted) begin
      if (wait_min != CNT_MAX) begin
        wait_min_d = wait_min + CNT_W'(1);
      end
      case (state_q)
        IDLE, FREE: begin
          if (FREE_NONE) begin
            // No free minutes: this minute already bills.
            bill_minute = 1'b1;
            state_d     = BILL;
          end else if (free_cnt_q < FREE_LIM) begin
            free_cnt_d = free_next;
            state_d    = (free_next == FREE_LIM) ? BILL : FREE;
          end else begin
            state_d = BILL;
          end
        end
        BILL:    bill_minute = 1'b1;
        default: state_d = IDLE;
      endcase

      // div_cnt survives a mode change; >= closes an overshot unit at once.
      if (bill_minute) begin
        if ({1'b0, div_cnt_q} + (DIV_W+1)'(1) >= period) begin
          div_cnt_d = '0;
          pulse_d   = 1'b1;
          if (wait_units != CNT_MAX) begin
            wait_units_d = wait_units + CNT_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
    end

    free_done_d = (state_d == BILL);
  end

endmodule

// File: tb/tb_wait_fare_counter.sv
// Directed testbench for wait_fare_counter: a default-parameter instance for
// reset, day billing, gating, night switch, clear and reset, plus a small
// instance (CNT_W=4, FREE_MIN=0, WAIT_COUNT=1) for saturation.
module tb_wait_fare_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       min_pulse, waiting, night_mode, clear;
  logic       wait_fare_pulse, free_done;
  logic [7:0] wait_min, wait_units;

  logic       sat_min, sat_clear;
  logic       sat_waiting = 1'b1;
  logic       sat_night = 1'b0;
  logic       sat_pulse, sat_free_done;
  logic [3:0] sat_wait_min, sat_wait_units;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int sat_pulses = 0;

  always #5 clk = ~clk;

  wait_fare_counter #(
    .CNT_W(8), .FREE_MIN(2), .WAIT_COUNT(5), .NIGHT_WAIT_COUNT(3)
  ) dut (
    .sys_clk         (clk),
    .rst_n           (rst_n),
    .min_pulse       (min_pulse),
    .waiting         (waiting),
    .night_mode      (night_mode),
    .clear           (clear),
    .wait_fare_pulse (wait_fare_pulse),
    .wait_min        (wait_min),
    .wait_units      (wait_units),
    .free_done       (free_done)
  );

  wait_fare_counter #(
    .CNT_W(4), .FREE_MIN(0), .WAIT_COUNT(1), .NIGHT_WAIT_COUNT(3)
  ) dut_sat (
    .sys_clk         (clk),
    .rst_n           (rst_n),
    .min_pulse       (sat_min),
    .waiting         (sat_waiting),
    .night_mode      (sat_night),
    .clear           (sat_clear),
    .wait_fare_pulse (sat_pulse),
    .wait_min        (sat_wait_min),
    .wait_units      (sat_wait_units),
    .free_done       (sat_free_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge, tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wait_fare_pulse === 1'b1) pulses++;
    if (sat_pulse === 1'b1) sat_pulses++;
  endtask

  task automatic chk_main(input string tag, input int m, input int u, input bit p, input bit fd);
    chk({tag, ".wait_min"},   32'(wait_min),        32'(m));
    chk({tag, ".wait_units"}, 32'(wait_units),      32'(u));
    chk({tag, ".pulse"},      32'(wait_fare_pulse), 32'(p));
    chk({tag, ".free_done"},  32'(free_done),       32'(fd));
  endtask

  // One minute strobe with the given waiting level; a gap cycle follows later.
  task automatic minute(input logic w);
    waiting   = w;
    min_pulse = 1'b1;
    tick();
    min_pulse = 1'b0;
    waiting   = 1'b1;
  endtask

  task automatic gap(input string tag);
    tick();
    chk({tag, ".gap_pulse"}, 32'(wait_fare_pulse), 32'd0);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_main(tag, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; min_pulse = 1'b0; waiting = 1'b1; night_mode = 1'b0; clear = 1'b0;
    sat_min = 1'b0; sat_clear = 1'b0;

    // Reset held 10 cycles with min_pulse toggling.
    for (int i = 0; i < 10; i++) begin
      min_pulse = (i % 2 == 0);
      tick();
      chk("reset.wait_min", 32'(wait_min), 32'd0);
      chk("reset.pulse", 32'(wait_fare_pulse), 32'd0);
    end
    min_pulse = 1'b0;
    chk_main("reset", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Day billing: 12 minutes, free_done after 2, pulses after 7 and 12.
    for (int m = 1; m <= 12; m++) begin
      minute(1'b1);
      chk_main($sformatf("day.m%0d", m), m, (m >= 12) ? 2 : (m >= 7) ? 1 : 0,
               (m == 7) || (m == 12), m >= 2);
      gap("day");
    end
    chk("day.pulse_total", 32'(pulses), 32'd2);
    do_clear("day.clear");

    // Gating and freeze: 4 counted, 3 gated off, 3 counted; pulse on 7th.
    for (int m = 1; m <= 4; m++) begin
      minute(1'b1);
      gap("gate");
    end
    for (int i = 0; i < 3; i++) begin
      minute(1'b0);
      chk_main("gate.frozen", 4, 0, 1'b0, 1'b1);
      gap("gate");
    end
    for (int m = 5; m <= 7; m++) begin
      minute(1'b1);
      chk_main($sformatf("gate.m%0d", m), m, (m == 7) ? 1 : 0, m == 7, 1'b1);
      gap("gate");
    end
    do_clear("gate.clear");

    // Night switch mid-unit: 2 free, 2 day (div_cnt=2), then night P=3.
    for (int m = 1; m <= 4; m++) begin
      minute(1'b1);
      chk_main($sformatf("night.day_m%0d", m), m, 0, 1'b0, m >= 2);
      gap("night");
    end
    night_mode = 1'b1;
    for (int m = 5; m <= 12; m++) begin
      minute(1'b1);
      chk_main($sformatf("night.m%0d", m), m, (m >= 11) ? 3 : (m >= 8) ? 2 : 1,
               (m == 5) || (m == 8) || (m == 11), 1'b1);
      gap("night");
    end
    night_mode = 1'b0;

    // Clear together with a counted minute mid-unit: clear wins.
    min_pulse = 1'b1;
    do_clear("clr_prio");
    min_pulse = 1'b0;
    for (int m = 1; m <= 2; m++) begin
      minute(1'b1);
      chk_main($sformatf("clr_prio.m%0d", m), m, 0, 1'b0, m == 2);
      gap("clr_prio");
    end

    // Reset mid-unit with a minute pending: everything back to 0.
    minute(1'b1);
    chk_main("mid.m3", 3, 0, 1'b0, 1'b1);
    rst_n = 1'b0;
    min_pulse = 1'b1;
    tick();
    min_pulse = 1'b0;
    chk_main("mid_reset", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Saturation: every minute bills; counters stick at 15.
    sat_pulses = 0;
    for (int m = 1; m <= 20; m++) begin
      sat_min = 1'b1;
      tick();
      sat_min = 1'b0;
      chk($sformatf("sat.m%0d.wait_min", m),   32'(sat_wait_min),   32'((m > 15) ? 15 : m));
      chk($sformatf("sat.m%0d.wait_units", m), 32'(sat_wait_units), 32'((m > 15) ? 15 : m));
      chk($sformatf("sat.m%0d.pulse", m),      32'(sat_pulse),      32'd1);
      chk($sformatf("sat.m%0d.free_done", m),  32'(sat_free_done),  32'd1);
      tick();
      chk("sat.gap_pulse", 32'(sat_pulse), 32'd0);
    end
    chk("sat.pulse_total", 32'(sat_pulses), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wait_fare_counter.md
# wait_fare_counter

Parametrised waiting-time fare divider for the taxi meter. It counts minute strobes while the cab is stopped with a passenger and grants a configurable number of free waiting minutes. After that it emits one wait-fare pulse per billed unit, using separate day and night unit lengths. It sits between the minute-tick generator and the fare accumulator, and tracks total waited minutes and billed units for the display.

## Interface
Parameters:
- CNT_W, 8, width of `wait_min` and `wait_units` (saturating)
- FREE_MIN, 2, free waiting minutes per trip (0 allowed, max 255)
- WAIT_COUNT, 5, minutes per billed unit in day mode (>=1, <=255)
- NIGHT_WAIT_COUNT, 3, minutes per billed unit in night mode (>=1, <=255)

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low (sampled on `sys_clk` rising edge)
- min_pulse  in  1  one-cycle strobe per elapsed minute, synchronous to `sys_clk`
- waiting  in  1  cab stopped with passenger; a minute is "counted" only when `min_pulse & waiting`
- night_mode  in  1  selects NIGHT_WAIT_COUNT when 1, else WAIT_COUNT
- clear  in  1  trip end / new trip; one-cycle or level
- wait_fare_pulse  out  1  one-cycle pulse per billed unit
- wait_min  out  CNT_W  total counted minutes this trip, saturates at 2^CNT_W-1
- wait_units  out  CNT_W  billed units this trip, saturates at 2^CNT_W-1
- free_done  out  1  high once free minutes are exhausted (state BILL)

## Operation
- Internal counters:
  - `free_cnt`: 8 bits.
  - `div_cnt`: 8 bits, minutes into the current unit.
- States:
  - IDLE: no minute counted since reset or clear.
  - FREE: free minutes being consumed.
  - BILL: billing active.
- Priority, in this order:
  1. `rst_n=0`
  2. `clear=1`
  3. counted minute
  4. hold
- Reset or clear sets state IDLE and zeroes all counters and outputs. No pulse is emitted in that cycle.
- Counted minute in IDLE or FREE:
  - `wait_min++`.
  - If `free_cnt < FREE_MIN`: `free_cnt++`. Next state is BILL if `free_cnt+1 == FREE_MIN`, else FREE.
  - If FREE_MIN = 0: the minute is handled as a BILL minute (below) and the state goes to BILL.
- Counted minute in BILL:
  - `wait_min++`.
  - Let P = NIGHT_WAIT_COUNT if `night_mode` is 1 in that cycle, else WAIT_COUNT.
  - If `div_cnt+1 >= P`: `div_cnt <= 0`, `wait_units++`, `wait_fare_pulse <= 1`.
  - Else: `div_cnt++`.
- Mode change mid-unit:
  - `div_cnt` is kept and compared against the new P.
  - If `div_cnt` is already at or above P-1, the unit completes on the next counted minute.
- `waiting=0` freezes all counters and state. Counting resumes from the same point when `waiting` returns; only `clear` restarts the trip.
- Saturation:
  - `wait_min` and `wait_units` stick at all-ones.
  - `wait_fare_pulse` is still emitted at unit boundaries after `wait_units` saturates.
- `free_done` = (state == BILL).

## Timing
- All outputs are registered. Every output resets to 0.
- A counted minute sampled at edge N produces:
  - the `wait_min` update visible after edge N;
  - `wait_fare_pulse` high for exactly the cycle between edges N and N+1.
- `wait_fare_pulse` is never high for 2 consecutive cycles.
- `min_pulse` held high for k cycles counts as k minutes. A strobe is the caller's responsibility.
- `clear` together with `min_pulse`: clear wins and the minute is discarded.
- `rst_n` low mid-unit: after the edge, everything is 0 and the state is IDLE. Partial `div_cnt` is lost.
- State transitions occur only on counted minutes, clear, or reset.

## Test plan
- **Reset:** hold `rst_n=0` for 10 cycles with `min_pulse` toggling and `waiting=1` -> all outputs 0, no pulse.
- **Day billing:** FREE_MIN=2, WAIT_COUNT=5, `waiting=1`, `night_mode=0`, 12 counted minutes.
  - `free_done` rises after minute 2.
  - Pulses after minutes 7 and 12.
  - End state: `wait_units`=2, `wait_min`=12.
- **Gating and freeze:** same parameters; minutes 1–4 with `waiting=1`, 3 minutes with `waiting=0`, then 3 minutes with `waiting=1`.
  - One pulse, after the 7th counted minute.
  - End state: `wait_min`=7.
- **Night switch mid-unit:** after free minutes, 2 day minutes (`div_cnt`=2), then set `night_mode=1` (P=3).
  - The next counted minute pulses.
  - Subsequent pulses every 3 minutes.
- **Clear priority:** `clear` and a counted minute in the same cycle, mid-unit -> outputs 0, state IDLE, no pulse. The next 2 minutes are free again.
- **Saturation:** CNT_W=4, FREE_MIN=0, WAIT_COUNT=1, 20 counted minutes.
  - `wait_min` and `wait_units` stick at 15.
  - 20 pulses total.
